// File: rtl/nn_acc_pkg.sv
// Shared constants and state type for the accumulate/requantise block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_acc_pkg;

    localparam int PROD_W_DEF = 47;
    localparam int ACC_W_DEF  = 56;
    localparam int BIAS_W_DEF = 32;
    localparam int OUT_W_DEF  = 8;

    // Largest right shift the datapath honours; larger requests clamp to this.
    localparam logic [5:0] MAX_SHIFT = 6'd55;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_RQ  = 2'd1,
        S_OUT = 2'd2
    } state_t;

endpackage

// File: rtl/nn_requant.sv
// Round / arithmetic-shift / ReLU / saturate of an accumulator to an unsigned activation.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
// Build option: NN_REQUANT_ROUND_EN adds a round-half-up term before the shift.
module nn_requant
    import nn_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [5:0]       shift,
    output logic        [OUT_W-1:0] out_tdata,
    output logic                    out_sat
);

    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam logic signed [ACC_W:0] QMAX = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef NN_REQUANT_ROUND_EN
    localparam logic signed [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};
`endif

    logic        [5:0] sh;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] q;

    // Clamp shift, optionally round, shift arithmetically, then clip to [0, 2^OUT_W-1].
    always_comb begin
        out_tdata = '0;
        out_sat   = 1'b0;
        sh = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
        r  = {acc[ACC_W-1], acc};
`ifdef NN_REQUANT_ROUND_EN
        if (sh != 6'd0) begin
            r = r + (RND_ONE <<< (sh - 6'd1));
        end
`endif
        q = r >>> sh;
        if (q[ACC_W]) begin
            out_tdata = '0;
            out_sat   = 1'b0;
        end else if (q > QMAX) begin
            out_tdata = '1;
            out_sat   = 1'b1;
        end else begin
            out_tdata = q[OUT_W-1:0];
            out_sat   = 1'b0;
        end
    end

endmodule

// File: rtl/nn_acc_requant.sv
// Accumulates a group of unsigned product beats onto a signed bias, then requantises to OUT_W bits.
// Latency: tlast beat accepted in cycle T -> out_tvalid high in cycle T+2.
// Backpressure: prod_tready low from tlast until the result is taken; result held while out_tready is low.
// Build option: NN_REQUANT_ROUND_EN selects round-half-up instead of truncation.
module nn_acc_requant
    import nn_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] prod_tdata,
    input  logic              prod_tvalid,
    output logic              prod_tready,
    input  logic              prod_tlast,
    input  logic [BIAS_W-1:0] bias,
    input  logic [5:0]        shift,
    output logic [OUT_W-1:0]  out_tdata,
    output logic              out_sat,
    output logic              out_tvalid,
    input  logic              out_tready
);

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic        [5:0]       shift_q;
    logic                    beat;
    logic        [ACC_W-1:0] prod_ext;
    logic        [ACC_W-1:0] bias_ext;
    logic        [OUT_W-1:0] rq_tdata;
    logic                    rq_sat;

    assign beat     = prod_tvalid & prod_tready;
    assign prod_ext = {{(ACC_W - PROD_W){1'b0}}, prod_tdata};
    assign bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and input-side ready.
    always_comb begin
        state_nxt   = state;
        prod_tready = 1'b0;
        case (state)
            S_ACC: begin
                prod_tready = 1'b1;
                if (prod_tvalid && prod_tlast) begin
                    state_nxt = S_RQ;
                end
            end
            S_RQ: begin
                state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_tready) begin
                    state_nxt = S_ACC;
                end
            end
            default: begin
                state_nxt = S_ACC;
            end
        endcase
    end

    // Accumulator, per-group shift, and the registered output beat.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc        <= '0;
            first      <= 1'b1;
            shift_q    <= '0;
            out_tdata  <= '0;
            out_sat    <= 1'b0;
            out_tvalid <= 1'b0;
        end else begin
            if (beat) begin
                if (first) begin
                    acc     <= bias_ext + prod_ext;
                    shift_q <= shift;
                end else begin
                    acc <= acc + prod_ext;
                end
                // The beat after a tlast always opens a new group.
                first <= prod_tlast;
            end
            if (state == S_RQ) begin
                out_tdata  <= rq_tdata;
                out_sat    <= rq_sat;
                out_tvalid <= 1'b1;
            end else if (state == S_OUT && out_tready) begin
                out_tvalid <= 1'b0;
            end
        end
    end

    nn_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc       (acc),
        .shift     (shift_q),
        .out_tdata (rq_tdata),
        .out_sat   (rq_sat)
    );

endmodule
